// File: rtl/fir_pkg.sv
// Shared constants for the serial symmetric FIR front end: feeder state
// encoding, status counter width and the phase-counter width helper.
package fir_pkg;

    localparam int UNDERRUN_CNT_W = 8;

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    function automatic int phase_width(input int n_taps);
        return (n_taps / 2 > 1) ? $clog2(n_taps / 2) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; push ignored when full,
// pop ignored when empty. Storage is not reset, only pointers and level.
module sync_fifo #(
    parameter int WIDTH_DATA      = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int LOG2_FIFO_DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH_DATA-1:0]      i_din,
    input  logic                       i_pop,
    output logic [WIDTH_DATA-1:0]      o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [LOG2_FIFO_DEPTH:0]   o_level
);

    localparam int LVL_W = LOG2_FIFO_DEPTH + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [WIDTH_DATA-1:0]      r_mem [FIFO_DEPTH];
    logic [LOG2_FIFO_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_FIFO_DEPTH-1:0] r_rd_ptr;
    logic [LVL_W-1:0]           r_level;
    logic                       w_do_push;
    logic                       w_do_pop;

    assign o_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + LOG2_FIFO_DEPTH'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + LOG2_FIFO_DEPTH'(1);
            if (w_do_push && !w_do_pop)
                r_level <= r_level + LVL_W'(1);
            else if (w_do_pop && !w_do_push)
                r_level <= r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// Rate adapter in front of the serial FIR: buffers a valid/ready stream and
// presents one held-stable sample every N_TAPS/2 cycles, zero-filling on underrun.
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int WIDTH_DATA      = 8,
    parameter int N_TAPS          = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int LOG2_FIFO_DEPTH = 3,
    parameter int PRIME_LEVEL     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    input  logic [WIDTH_DATA-1:0]      s_data,
    output logic                       s_ready,
    output logic [WIDTH_DATA-1:0]      fir_din,
    output logic                       sample_strobe,
    output logic                       running,
    output logic                       underrun,
    input  logic                       underrun_clr,
    output logic [UNDERRUN_CNT_W-1:0]  underrun_count,
    output logic [LOG2_FIFO_DEPTH:0]   fill_level
);

    localparam int P       = N_TAPS / 2;
    localparam int PHASE_W = phase_width(N_TAPS);
    localparam int LVL_W   = LOG2_FIFO_DEPTH + 1;
    localparam logic [PHASE_W-1:0]        PHASE_LAST = PHASE_W'(P - 1);
    localparam logic [LVL_W-1:0]          PRIME_LVL  = LVL_W'(PRIME_LEVEL);
    localparam logic [UNDERRUN_CNT_W-1:0] CNT_MAX    = '1;

    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(
        input logic [UNDERRUN_CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + UNDERRUN_CNT_W'(1);
    endfunction

    logic [PHASE_W-1:0]        r_phase;
    logic [0:0]                r_state;
    logic [WIDTH_DATA-1:0]     r_fir_din;
    logic                      r_strobe;
    logic                      r_underrun;
    logic [UNDERRUN_CNT_W-1:0] r_underrun_cnt;

    logic                      w_decide;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_underrun_evt;
    logic [LVL_W-1:0]          w_level;
    logic [WIDTH_DATA-1:0]     w_head;

    assign w_decide = (r_phase == PHASE_LAST);
    assign w_push   = s_valid & ~w_full;
    // Pop decision uses pre-edge occupancy, so a same-cycle push into an empty FIFO is not bypassed.
    assign w_pop    = w_decide & ~w_empty &
                      ((r_state == ST_RUN) | (w_level >= PRIME_LVL));
    assign w_underrun_evt = w_decide & (r_state == ST_RUN) & w_empty;

    sync_fifo #(
        .WIDTH_DATA      (WIDTH_DATA),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .LOG2_FIFO_DEPTH (LOG2_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (s_data),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase        <= '0;
            r_state        <= ST_PRIME;
            r_fir_din      <= '0;
            r_strobe       <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_phase  <= w_decide ? '0 : r_phase + PHASE_W'(1);
            r_strobe <= w_decide;
            if (w_decide) begin
                r_fir_din <= w_pop ? w_head : '0;
                r_state   <= w_pop ? ST_RUN : ST_PRIME;
            end
            // An underrun landing with a clear leaves a fresh count of one.
            if (w_underrun_evt) begin
                r_underrun     <= 1'b1;
                r_underrun_cnt <= sat_inc(underrun_clr ? '0 : r_underrun_cnt);
            end else if (underrun_clr) begin
                r_underrun     <= 1'b0;
                r_underrun_cnt <= '0;
            end
        end
    end

    assign s_ready        = ~w_full;
    assign fir_din        = r_fir_din;
    assign sample_strobe  = r_strobe;
    assign running        = (r_state == ST_RUN);
    assign underrun       = r_underrun;
    assign underrun_count = r_underrun_cnt;
    assign fill_level     = w_level;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: queue-based reference model stepped each clock,
// all outputs compared every cycle under directed and random traffic.
module tb_fir_sample_feeder;

    localparam int WD    = 8;
    localparam int NT    = 16;
    localparam int DEPTH = 8;
    localparam int LOG2  = 3;
    localparam int PRIME = 4;
    localparam int P     = NT / 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic [WD-1:0]   s_data;
    logic            s_ready;
    logic [WD-1:0]   fir_din;
    logic            sample_strobe;
    logic            running;
    logic            underrun;
    logic            underrun_clr;
    logic [7:0]      underrun_count;
    logic [LOG2:0]   fill_level;

    fir_sample_feeder #(
        .WIDTH_DATA      (WD),
        .N_TAPS          (NT),
        .FIFO_DEPTH      (DEPTH),
        .LOG2_FIFO_DEPTH (LOG2),
        .PRIME_LEVEL     (PRIME)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .fir_din        (fir_din),
        .sample_strobe  (sample_strobe),
        .running        (running),
        .underrun       (underrun),
        .underrun_clr   (underrun_clr),
        .underrun_count (underrun_count),
        .fill_level     (fill_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s at %0t: got %0h want %0h", tag, $time, act, exp);
        end
    endtask

    // Reference: FIFO contents as a queue, time as cycles since reset.
    logic [WD-1:0] mq[$];
    int            m_t;
    bit            m_run;
    bit            m_strobe;
    bit            m_under;
    int            m_din;
    int            m_cnt;

    task automatic model_step();
        bit decide;
        bit ready;
        bit evt;
        if (!rst) begin
            mq.delete();
            m_t = 0; m_run = 0; m_strobe = 0; m_din = 0; m_under = 0; m_cnt = 0;
            return;
        end
        ready  = mq.size() < DEPTH;
        decide = (m_t % P) == P - 1;
        evt    = decide && m_run && mq.size() == 0;
        m_strobe = decide;
        if (evt) begin
            m_under = 1;
            m_cnt   = underrun_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (underrun_clr) begin
            m_under = 0;
            m_cnt   = 0;
        end
        if (decide) begin
            if (mq.size() > 0 && (m_run || mq.size() >= PRIME)) begin
                m_din = int'(mq.pop_front());
                m_run = 1;
            end else begin
                m_din = 0;
                m_run = 0;
            end
        end
        if (s_valid && ready) mq.push_back(s_data);
        m_t++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("s_ready",        32'(s_ready),        32'(mq.size() < DEPTH));
        chk("fill_level",     32'(fill_level),     32'(mq.size()));
        chk("sample_strobe",  32'(sample_strobe),  32'(m_strobe));
        chk("fir_din",        32'(fir_din),        32'(m_din));
        chk("running",        32'(running),        32'(m_run));
        chk("underrun",       32'(underrun),       32'(m_under));
        chk("underrun_count", 32'(underrun_count), 32'(m_cnt));
    endtask

    initial begin
        logic [WD-1:0] prime_vals [4];
        int d;
        bit acc;
        int waited;
        prime_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst = 1'b0; s_valid = 1'b1; s_data = 8'hAA; underrun_clr = 1'b0;
        repeat (3) cycle();
        rst = 1'b1; s_valid = 1'b0;

        // Priming with four back-to-back samples.
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = prime_vals[i];
            cycle();
        end
        s_valid = 1'b0;

        // Drain into underrun; clear pulses on decision cycles and the cycle after.
        for (int i = 0; i < 60; i++) begin
            underrun_clr = ((m_t % P) == P - 1) || ((m_t % P) == 0);
            cycle();
        end
        underrun_clr = 1'b0;

        // Backpressure: upstream holds each value until it is accepted.
        d = 1;
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1; s_data = 8'(d);
            acc = mq.size() < DEPTH;
            cycle();
            if (acc) d++;
        end
        s_valid = 1'b0;
        repeat (90) cycle();

        // Reach RUN with five samples buffered, then reset for one cycle.
        waited = 0;
        while (!(m_run && mq.size() == 5) && waited < 200) begin
            s_valid = (mq.size() < 5);
            s_data  = 8'($urandom);
            cycle();
            waited++;
        end
        chk("reach_run_fill5", 32'(m_run && mq.size() == 5), 32'd1);
        rst = 1'b0; s_valid = 1'b1; s_data = 8'h5A;
        cycle();
        rst = 1'b1; s_valid = 1'b0;
        repeat (20) cycle();

        // Repeated prime/drain to push the underrun count into saturation.
        repeat (262) begin
            s_valid = 1'b1;
            repeat (4) begin
                s_data = 8'($urandom);
                cycle();
            end
            s_valid = 1'b0;
            repeat (56) cycle();
        end

        // Random traffic with varying density, occasional clears and resets.
        for (int seg = 0; seg < 40; seg++) begin
            int dens;
            dens = int'($urandom_range(1, 16));
            for (int i = 0; i < 100; i++) begin
                s_valid      = (int'($urandom_range(0, 15)) < dens);
                s_data       = 8'($urandom);
                underrun_clr = ($urandom_range(0, 31) == 0);
                rst          = ($urandom_range(0, 499) != 0);
                cycle();
            end
        end
        rst = 1'b1; s_valid = 1'b0; underrun_clr = 1'b0;
        repeat (10) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
- Upstream stage of the serial symmetric FIR. Accepts input samples over a valid/ready stream at an arbitrary rate.
- Buffers samples in a small synchronous FIFO and presents exactly one sample per FIR sample period (N_TAPS/2 clk cycles) on a registered, held-stable data output that drives the FIR din.
- Handles start-up priming and underrun by inserting zero samples, and reports underrun status.

Parameters:
- WIDTH_DATA, 8, sample width; must match FIR WIDTH_DATA.
- N_TAPS, 16, FIR tap count; sample period P = N_TAPS/2 clk cycles; N_TAPS even, at least 4.
- FIFO_DEPTH, 8, buffer entries; power of two.
- LOG2_FIFO_DEPTH, 3, log2(FIFO_DEPTH).
- PRIME_LEVEL, 4, fill level required before leaving PRIME; range 1..FIFO_DEPTH.

Ports:
- clk  in  1  system clock, same clock as the FIR MAC datapath.
- rst  in  1  synchronous reset, active-low: asserted when rst=0 at a clk rising edge.
- s_valid  in  1  upstream sample valid.
- s_data  in  WIDTH_DATA  upstream sample.
- s_ready  out  1  feeder can accept a sample; equals not-full.
- fir_din  out  WIDTH_DATA  registered sample to the FIR din; changes only on strobe cycles.
- sample_strobe  out  1  one-cycle pulse, the cycle fir_din updates.
- running  out  1  high in RUN state.
- underrun  out  1  sticky; set on an underrun in RUN; cleared by underrun_clr or reset.
- underrun_clr  in  1  clears underrun and underrun_count.
- underrun_count  out  8  saturating count of underruns.
- fill_level  out  LOG2_FIFO_DEPTH+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst=0 at edge) is synchronous and has priority over all other activity. It forces:
  - phase=0, FIFO empty, fill_level=0;
  - fir_din=0, sample_strobe=0, state=PRIME, running=0;
  - underrun=0, underrun_count=0;
  - s_ready=1 from the first cycle after reset.
- Reset mid-operation discards all FIFO contents, with no drain.
- Phase counter: counts 0..P-1 and wraps. sample_strobe is registered and is 1 in the cycle after phase==P-1. First strobe occurs P cycles after reset release; thereafter every P cycles.
- Push: occurs when s_valid and s_ready are both 1. Data is written at the tail, and fill_level increments the next cycle.
- s_ready = (fill_level != FIFO_DEPTH). It is combinational from registered state, so a pop in the same cycle does not raise s_ready while full.
- Pop decision is made at phase==P-1; the popped value appears on fir_din with sample_strobe, one cycle later.
- Simultaneous push and pop: both take effect and fill_level is unchanged. A push into an empty FIFO in the same cycle as a pop decision is not bypassed; the FIFO is treated as empty for that decision.
- State machine (2 states, evaluated at phase==P-1):
  - PRIME: no pop; fir_din loads 0; underruns are not counted. Transition to RUN when fill_level >= PRIME_LEVEL.
  - RUN: if FIFO non-empty, pop the head into fir_din. If empty (underrun), then:
    - fir_din loads 0;
    - underrun is set;
    - underrun_count increments, saturating at 255;
    - state returns to PRIME.
  - The PRIME-to-RUN transition and the first pop happen on the same decision edge, so the first strobe in RUN already carries the head sample.
- underrun_clr vs underrun event in the same cycle: the event wins. Result is underrun=1 and underrun_count=1.
- Sample order is strictly FIFO order; samples are never dropped or duplicated.
- Output fir_din is held constant for P cycles between strobes. This stability is what allows the FIR input register to sample on its divided clock.

Decomposition:
- Shared package fir_pkg holds:
  - function for phase width $clog2(N_TAPS/2);
  - feeder state encoding (PRIME=0, RUN=1);
  - underrun counter width constant (8).
- One sub-module: sync_fifo, parameterised on WIDTH_DATA/FIFO_DEPTH, with a push/pop interface and full/empty/level outputs. It uses the same clk and active-low synchronous rst.
- Phase counter, FSM, output register and status logic live in fir_sample_feeder.

Test Plan:
- Reset: hold rst=0 for 3 cycles with s_valid=1. Required: fir_din=0, fill_level=0, s_ready=1, running=0. Release rst; first sample_strobe occurs 8 cycles later with fir_din=0 (defaults, P=8).
- Priming: push 0x11,0x22,0x33,0x44 back-to-back. Required: at the next phase==7, state goes to RUN; the following strobe shows fir_din=0x11, then 0x22, 0x33, 0x44 on successive strobes 8 cycles apart; fill_level decrements once per strobe.
- Backpressure: hold s_valid=1 with no pops (PRIME_LEVEL=8 variant). Required: s_ready drops after 8 pushes; the 9th value is not accepted; values 1..8 are later emitted in order.
- Underrun: in RUN, stop pushes after 2 samples. Required:
  - 3rd strobe shows fir_din=0, underrun=1, underrun_count=1, running=0;
  - refill with 4 samples returns to RUN; the next strobe shows the first refill sample.
- Clear collision: assert underrun_clr in the same cycle as an underrun decision. Required: underrun=1, underrun_count=1. A clr alone on the next cycle gives underrun=0, count=0.
- Mid-run reset: pull rst=0 for 1 cycle while fill_level=5 in RUN. Required: the next cycle shows fill_level=0, fir_din=0, running=0, phase restarted; no pre-reset sample ever appears on fir_din.
